ospfb_phase_sequencer: RTL and testbench
========================================

Name: ospfb_phase_sequencer

Overview:
- Runtime-configurable frame and phase sequencer for the oversampled PFB. It replaces the fixed compile-time decimation ratio with a decimation factor D chosen at run time.
- Runs the per-clock word counter over each M-point frame and gates the ADC stream so that exactly D new samples enter per frame.
- Tracks the circular-shift phase state (shift += D mod M) that the PE chain and FFT input reorder consume.
- Sits between the ADC AXIS source and the PTAPS PE chain.

Parameters:
FFT_LEN, 2048, M: polyphase branches; power of two; divisible by SAMP_PER_CLK
SAMP_PER_CLK, 2, samples per clock word
DEC_FAC_INIT, 1536, D loaded at reset; multiple of SAMP_PER_CLK, 0 < D <= M
FRAME_CNT_WID, 16, width of frame counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  sequencer enable; 0 freezes all state
cfg_dec_fac  in  $clog2(FFT_LEN)+1  requested D in samples
cfg_load  in  1  one-cycle strobe requesting cfg_dec_fac
cfg_err  out  1  sticky: rejected cfg_load; cleared by rst_n only
cur_dec_fac  out  $clog2(FFT_LEN)+1  D currently in force
s_valid  in  1  ADC word valid
s_ready  out  1  ADC word accepted this cycle (combinational)
m_valid  out  1  sequence word valid
m_ready  in  1  downstream accept
m_word_idx  out  $clog2(FFT_LEN/SAMP_PER_CLK)  word index k within frame
m_new_samp  out  1  word k carries a freshly accepted ADC word
m_sof  out  1  k == 0
m_eof  out  1  k == M/SPC-1
m_shift  out  $clog2(FFT_LEN)  phase-rotation state for this frame, in samples
m_frame_cnt  out  FRAME_CNT_WID  frame number, wraps

Behaviour:
- Let W = M/SPC and Dw = D/SPC.
- Word k needs input iff k >= W-Dw. The first W-Dw words of a frame are recirculated from the delay lines.
- Reset values: m_valid=0, m_word_idx=0, m_new_samp=0, m_sof=0, m_eof=0, m_shift=0, m_frame_cnt=0, cfg_err=0, cur_dec_fac=DEC_FAC_INIT.
- Internal state after reset: k=0, shift=0, pending config empty.
- Reset is asynchronous; rst_n asserted mid-frame returns everything to these values immediately.
- Handshake signals:
  - free = !m_valid || m_ready
  - need = (k >= W-Dw)
  - s_ready = en && free && need
  - advance = en && free && (!need || s_valid)
- On advance (registered outputs, latency 1 cycle):
  - m_valid <= 1, m_word_idx <= k, m_new_samp <= need, m_sof <= (k==0), m_eof <= (k==W-1).
  - m_shift <= shift, m_frame_cnt <= frame.
  - Then k <= k+1, wrapping to 0 after W-1.
- If not advance and m_ready=1, m_valid <= 0. Outputs hold while m_valid && !m_ready, with no loss or duplication.
- If need && !s_valid, the sequencer stalls: no advance, s_ready=1, k holds.
- Frame wrap, on the advance with k == W-1:
  - shift <= (shift + D) mod M, computed with an M-bit add and mask.
  - frame <= frame+1, wrapping at 2^FRAME_CNT_WID.
  - If a pending config exists: cur_dec_fac <= pending, then clear pending. The new D takes effect at k=0 of the next frame, and the wrap shift uses the old D.
- cfg_load handling:
  - Accepted iff cfg_dec_fac != 0, cfg_dec_fac <= M, and cfg_dec_fac mod SPC == 0. An accepted value is stored as pending; the last one before the frame wrap wins.
  - Otherwise cfg_err <= 1 and pending is unchanged.
  - cfg_load is processed regardless of en.
  - cfg_load in the same cycle as the wrap advance: the previous pending value applies at this wrap, and the new value stays pending for the next wrap.
- D == M is the critically sampled case: need is always 1, shift is always 0.
- en=0: s_ready=0 and no advance. The m_valid/m_ready drain still operates.

Decomposition:
- alpaca_constants_pkg gains:
  - OSPFB_WORDS = FFT_LEN/SAMP_PER_CLK
  - SHIFT_WID = $clog2(FFT_LEN)
  - DEC_WID = $clog2(FFT_LEN)+1
  - typedef ospfb_seq_t, a packed struct of {word_idx, new_samp, sof, eof, shift, frame_cnt}, so downstream PEs carry sequence info as one field.
- One natural sub-module, ospfb_cfg_shadow: validates and holds the pending D, and commits it on the frame-wrap strobe.

Test Plan:
1. M=16, SPC=2, D=12, s_valid=1, m_ready=1 -> per frame, m_new_samp=0 for k=0..1 and 1 for k=2..7; m_shift sequence 0,12,8,4,0; s_ready high for 6 of 8 cycles.
2. D=16 (critically sampled) -> m_new_samp always 1, m_shift always 0, zero input stall cycles.
3. Mid-frame cfg_load with D=8 while D=12 -> current frame finishes with D=12, wrap shift is +12, next frame needs input only for k=4..7, cur_dec_fac=8 from k=0.
4. cfg_load with 0, 18, or 7 -> cfg_err=1 and sticky, cur_dec_fac unchanged, sequence unaffected.
5. Random m_ready and s_valid backpressure -> m_word_idx strictly k+1 mod W across accepted words, no duplicates, one accepted ADC word per m_new_samp.
6. rst_n low for 1 cycle at k=5 of frame 3 -> all outputs 0 asynchronously; after release, restart at k=0, shift=0, frame=0, cur_dec_fac=DEC_FAC_INIT.

Source files
------------

// File: rtl/ospfb_phase_sequencer_pkg.sv
// Shared widths, the per-word sequence record and the decimation-factor legality rule
// for the oversampled PFB frame/phase sequencer.
package ospfb_phase_sequencer_pkg;

  localparam int FFT_LEN_DEF       = 2048;
  localparam int SAMP_PER_CLK_DEF  = 2;
  localparam int FRAME_CNT_WID_DEF = 16;

  localparam int OSPFB_WORDS   = FFT_LEN_DEF / SAMP_PER_CLK_DEF;
  localparam int SHIFT_WID     = $clog2(FFT_LEN_DEF);
  localparam int DEC_WID       = $clog2(FFT_LEN_DEF) + 1;
  localparam int WORD_IDX_WID  = $clog2(OSPFB_WORDS);

  // Sequence information carried alongside each word down the PE chain.
  typedef struct packed {
    logic [WORD_IDX_WID-1:0]      word_idx;
    logic                         new_samp;
    logic                         sof;
    logic                         eof;
    logic [SHIFT_WID-1:0]         shift;
    logic [FRAME_CNT_WID_DEF-1:0] frame_cnt;
  } ospfb_seq_t;

  // A decimation factor is usable when it is a non-zero whole number of words no larger than M.
  function automatic logic dec_fac_ok(input int unsigned d, input int unsigned m,
                                      input int unsigned spc);
    return (d != 0) && (d <= m) && ((d % spc) == 0);
  endfunction

endpackage

// File: rtl/ospfb_cfg_shadow.sv
// Validates run-time decimation-factor requests, holds the latest legal one as pending,
// and swaps it into force on the frame-wrap strobe.
module ospfb_cfg_shadow
  import ospfb_phase_sequencer_pkg::*;
#(
  parameter int FFT_LEN      = 2048,
  parameter int SAMP_PER_CLK = 2,
  parameter int DEC_FAC_INIT = 1536,
  localparam int DW          = $clog2(FFT_LEN) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_load,
  input  logic [DW-1:0] cfg_dec_fac,
  input  logic          commit,
  output logic [DW-1:0] cur_dec_fac,
  output logic          cfg_err
);

  logic [DW-1:0] pending;
  logic          pending_vld;
  logic          cfg_ok;

  assign cfg_ok = dec_fac_ok(32'(cfg_dec_fac), FFT_LEN, SAMP_PER_CLK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_vld <= 1'b0;
      cur_dec_fac <= DW'(DEC_FAC_INIT);
      cfg_err     <= 1'b0;
    end else begin
      if (commit && pending_vld) begin
        cur_dec_fac <= pending;
        pending_vld <= 1'b0;
      end
      // A load coinciding with a commit lands after it, so it waits for the next wrap.
      if (cfg_load) begin
        if (cfg_ok) begin
          pending     <= cfg_dec_fac;
          pending_vld <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ospfb_phase_sequencer.sv
// Runtime-configurable frame/phase sequencer: walks word index k over each frame, gates
// ADC words so D new samples enter per frame, and tracks the circular-shift phase.
module ospfb_phase_sequencer
  import ospfb_phase_sequencer_pkg::*;
#(
  parameter int FFT_LEN       = 2048,
  parameter int SAMP_PER_CLK  = 2,
  parameter int DEC_FAC_INIT  = 1536,
  parameter int FRAME_CNT_WID = 16,
  localparam int W            = FFT_LEN / SAMP_PER_CLK,
  localparam int DW           = $clog2(FFT_LEN) + 1,
  localparam int SW           = $clog2(FFT_LEN),
  localparam int KW           = $clog2(FFT_LEN / SAMP_PER_CLK)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DW-1:0]            cfg_dec_fac,
  input  logic                     cfg_load,
  output logic                     cfg_err,
  output logic [DW-1:0]            cur_dec_fac,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [KW-1:0]            m_word_idx,
  output logic                     m_new_samp,
  output logic                     m_sof,
  output logic                     m_eof,
  output logic [SW-1:0]            m_shift,
  output logic [FRAME_CNT_WID-1:0] m_frame_cnt
);

  // Handshakes: the output slot is free when empty or being drained (free = !m_valid || m_ready).
  // A word needing ADC input advances only with s_valid; s_ready = en && free && need.
  // m_valid/m_ready is standard valid/ready: outputs hold stable while m_valid && !m_ready.

  logic [KW-1:0]            k;
  logic [SW-1:0]            shift;
  logic [FRAME_CNT_WID-1:0] frame;
  logic [DW-1:0]            dw_words;
  logic [DW-1:0]            need_start;
  logic [DW-1:0]            shift_sum;
  logic                     free;
  logic                     need;
  logic                     last;
  logic                     advance;
  logic                     wrap;

  assign dw_words   = cur_dec_fac / DW'(SAMP_PER_CLK);
  assign need_start = DW'(W) - dw_words;
  assign need       = (DW'(k) >= need_start);
  assign last       = (k == KW'(W - 1));
  assign free       = !m_valid || m_ready;
  assign s_ready    = en && free && need;
  assign advance    = en && free && (!need || s_valid);
  assign wrap       = advance && last;

  // M is a power of two, so the modulo is just dropping the carry bit.
  assign shift_sum  = {1'b0, shift} + cur_dec_fac;

  ospfb_cfg_shadow #(
    .FFT_LEN      (FFT_LEN),
    .SAMP_PER_CLK (SAMP_PER_CLK),
    .DEC_FAC_INIT (DEC_FAC_INIT)
  ) u_cfg_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_dec_fac (cfg_dec_fac),
    .commit      (wrap),
    .cur_dec_fac (cur_dec_fac),
    .cfg_err     (cfg_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      shift       <= '0;
      frame       <= '0;
      m_valid     <= 1'b0;
      m_word_idx  <= '0;
      m_new_samp  <= 1'b0;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      m_shift     <= '0;
      m_frame_cnt <= '0;
    end else if (advance) begin
      m_valid     <= 1'b1;
      m_word_idx  <= k;
      m_new_samp  <= need;
      m_sof       <= (k == '0);
      m_eof       <= last;
      m_shift     <= shift;
      m_frame_cnt <= frame;
      if (last) begin
        k     <= '0;
        shift <= shift_sum[SW-1:0];
        frame <= frame + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ospfb_phase_sequencer.sv
// Bench for ospfb_phase_sequencer at M=16, SPC=2, D=12: frame-level reference model,
// directed frames, config changes, random backpressure and an asynchronous mid-frame reset.
module tb_ospfb_phase_sequencer;

  localparam int M    = 16;
  localparam int SPC  = 2;
  localparam int DINI = 12;
  localparam int W    = M / SPC;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] cfg_dec_fac;
  logic       cfg_load;
  logic       cfg_err;
  logic [4:0] cur_dec_fac;
  logic       s_valid;
  logic       s_ready;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] m_word_idx;
  logic       m_new_samp;
  logic       m_sof;
  logic       m_eof;
  logic [3:0] m_shift;
  logic [15:0] m_frame_cnt;

  always #5 clk = ~clk;

  ospfb_phase_sequencer #(
    .FFT_LEN       (M),
    .SAMP_PER_CLK  (SPC),
    .DEC_FAC_INIT  (DINI),
    .FRAME_CNT_WID (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_dec_fac (cfg_dec_fac),
    .cfg_load    (cfg_load),
    .cfg_err     (cfg_err),
    .cur_dec_fac (cur_dec_fac),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_word_idx  (m_word_idx),
    .m_new_samp  (m_new_samp),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .m_shift     (m_shift),
    .m_frame_cnt (m_frame_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: next word k, frame number, phase, D in force, pending D (-1 = none).
  int mk, mframe, mshift, md, mpend;
  bit merr;
  bit mon_on  = 1'b0;
  bit rec_sof = 1'b0;
  int n_adc, n_new;
  int sof_shifts[$];
  logic [25:0] exp_q[$];
  logic [25:0] got_w;
  bit free_e, need_e, sr_e, adv_e;

  task automatic model_reset();
    mk = 0; mframe = 0; mshift = 0; md = DINI; mpend = -1; merr = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [25:0] pack_word(int k, bit ns, int sh, int fr);
    return {3'(k), ns, (k == 0), (k == W - 1), 4'(sh), 16'(fr)};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      free_e = (exp_q.size() == 0) || m_ready;
      need_e = (mk >= W - md / SPC);
      sr_e   = en && free_e && need_e;
      adv_e  = en && free_e && (!need_e || s_valid);

      check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      if (m_valid && exp_q.size() != 0) begin
        got_w = {m_word_idx, m_new_samp, m_sof, m_eof, m_shift, m_frame_cnt};
        check("word", 32'(got_w), 32'(exp_q[0]));
      end
      check("s_ready", 32'(s_ready), 32'(sr_e));
      check("cur_dec_fac", 32'(cur_dec_fac), 32'(md));
      check("cfg_err", 32'(cfg_err), 32'(merr));

      if (s_valid && s_ready) n_adc++;
      if (m_valid && m_ready && m_new_samp) n_new++;
      if (rec_sof && m_valid && m_ready && m_sof) sof_shifts.push_back(int'(m_shift));

      if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
      if (adv_e) begin
        exp_q.push_back(pack_word(mk, need_e, mshift, mframe));
        if (mk == W - 1) begin
          mk     = 0;
          mshift = (mshift + md) % M;
          mframe = (mframe + 1) % 65536;
          if (mpend >= 0) begin
            md    = mpend;
            mpend = -1;
          end
        end else begin
          mk++;
        end
      end
      if (cfg_load) begin
        if (cfg_dec_fac != 0 && cfg_dec_fac <= M && (cfg_dec_fac % SPC) == 0) mpend = int'(cfg_dec_fac);
        else merr = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; s_valid = 1'b0; m_ready = 1'b0; cfg_load = 1'b0; cfg_dec_fac = '0;
  endtask

  task automatic apply_reset();
    mon_on = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    model_reset();
    rst_n  = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic run_full(input int n);
    en = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic load_cfg(input int v);
    cfg_load = 1'b1; cfg_dec_fac = 5'(v);
    step();
    cfg_load = 1'b0;
  endtask

  task automatic wait_model_k(input int k, input int fr, input string tag);
    int i;
    for (i = 0; i < 200 && !(mk == k && (fr < 0 || mframe == fr)); i++) step();
    if (i == 200) check(tag, 32'(mk), 32'(k));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_fields"}, 32'({m_word_idx, m_new_samp, m_sof, m_eof, m_shift, m_frame_cnt}), 32'd0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_dec_fac"}, 32'(cur_dec_fac), 32'(DINI));
  endtask

  // ---------------- stimulus ----------------
  int exp_sof[5];

  initial begin
    exp_sof = '{0, 12, 8, 4, 0};
    n_adc = 0; n_new = 0;
    model_reset();
    apply_reset();
    check_reset_outputs("reset");

    // Free-flowing D=12: five frames, phase 0,12,8,4,0.
    rec_sof = 1'b1;
    run_full(5 * W + 3);
    rec_sof = 1'b0;
    check("sof_count", 32'(sof_shifts.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < sof_shifts.size(); i++) check("sof_shift", 32'(sof_shifts[i]), 32'(exp_sof[i]));

    // Critically sampled D=16, then back to D=12.
    load_cfg(16);
    run_full(4 * W);
    load_cfg(12);
    run_full(2 * W);

    // Mid-frame switch to D=8.
    wait_model_k(3, -1, "wait_k3");
    load_cfg(8);
    run_full(3 * W);
    check("dec_after_switch", 32'(cur_dec_fac), 32'd8);

    // Illegal requests are rejected and sticky.
    load_cfg(0);
    run_full(3);
    load_cfg(18);
    run_full(3);
    load_cfg(7);
    run_full(2 * W);
    check("cfg_err_sticky", 32'(cfg_err), 32'd1);
    check("dec_unchanged", 32'(cur_dec_fac), 32'd8);

    // Random backpressure, enable and config traffic.
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      s_valid  = ($urandom_range(0, 9) < 7);
      m_ready  = ($urandom_range(0, 9) < 7);
      cfg_load = ($urandom_range(0, 29) == 0);
      cfg_dec_fac = 5'($urandom_range(0, 20));
      step();
    end
    cfg_load = 1'b0;
    en = 1'b0; m_ready = 1'b1;
    repeat (3) step();
    check("adc_vs_new_samp", 32'(n_adc), 32'(n_new));

    // Asynchronous reset at k=5 of frame 3.
    apply_reset();
    run_full(1);
    wait_model_k(5, 3, "wait_k5_f3");
    #2;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check("async_s_ready", 32'(s_ready), 32'd0);
    step();
    model_reset();
    rst_n  = 1'b1;
    mon_on = 1'b1;
    run_full(2 * W + 2);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
